// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for fetch_queue.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both 1; the producer holds valid and payload stable until that edge, and ready never depends combinationally on valid.
interface fetch_queue_if #(
  parameter int PC_W   = 32,
  parameter int OFF_W  = 3,
  parameter int INST_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic              in_mode;
  logic [OFF_W-1:0]  in_off;
  logic [INST_W-1:0] in_inst;

  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic              out_mode;
  logic [OFF_W-1:0]  out_off;
  logic [INST_W-1:0] out_inst;

  modport master (
    output in_valid, in_pc, in_mode, in_off, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_mode, out_off, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_mode, in_off, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_mode, out_off, out_inst
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry circular instruction queue between fetch and decode.
// Registered-only ready/valid, one-cycle minimum latency, synchronous flush on redirect.
module fetch_queue #(
  parameter int  PC_W   = 32,
  parameter int  OFF_W  = 3,
  parameter int  INST_W = 48,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  fetch_queue_if.slave     bus,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + 1 + OFF_W + INST_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // Both handshake outputs come from the count register alone, so neither
  // out_ready nor flush has a combinational path back to fetch.
  assign bus.in_ready  = (count != FULL_CNT);
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid  & bus.in_ready  & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  assign head = mem[rd_ptr];
  assign {bus.out_pc, bus.out_mode, bus.out_off, bus.out_inst} = head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared only by reset; flush just rewinds the pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {bus.in_pc, bus.in_mode, bus.in_off, bus.in_inst};
    end
  end
endmodule
